// File: rtl/data_mem_sized.sv
// Wait-stated MIPS data memory: byte/half/word loads and stores with sign/zero extension,
// alignment rejection and a req/ready handshake. Each access is latched, stalled, then committed.
module data_mem_sized #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sx_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, commit, misalign;
  logic [AW-1:0] widx;
  logic [31:0]   word, wrep, wmerge, load_val;
  logic [3:0]    be;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          unused_addr;

  // Address bits above the word index alias back into the array.
  assign unused_addr = ^address[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        accept  = 1'b1;
        cnt_d   = 8'(WAIT_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q != '0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        commit  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    widx     = addr_q[AW+1:2];
    word     = mem[widx];
    misalign = (size_q == 2'b11) ||
               (size_q == 2'b01 && addr_q[0]) ||
               (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    lane_b   = 8'(word >> {addr_q[1:0], 3'b000});
    lane_h   = addr_q[1] ? word[31:16] : word[15:0];
    unique case (size_q)
      2'b00:   load_val = {{24{sx_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{sx_q & lane_h[15]}}, lane_h};
      default: load_val = word;
    endcase
    unique case (size_q)
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = '1;
        wrep = wdata_q;
      end
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      wmerge[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end
    rdata_d = (commit && !we_q && !misalign) ? load_val : rdata_q;
    err_d   = commit ? misalign : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      we_q    <= we;
      size_q  <= size;
      sx_q    <= sign_ext;
      addr_q  <= address[AW+1:0];
      wdata_q <= write_data;
    end
  end

  // Reset on the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && !misalign) begin
      mem[widx] <= wmerge;
    end
  end

  assign read_data = rdata_q;
  assign ready     = (state_q == S_DONE);
  assign err       = ready & err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench: two instances, zero wait states (deep) and three wait states (64 words).
module tb_data_mem_sized;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, sx0 = 1'b0;
  logic [1:0]  size0 = 2'b10;
  logic [31:0] addr0 = '0, wd0 = '0, rd0;
  logic        rdy0, err0;
  logic        req1 = 1'b0, we1 = 1'b0, sx1 = 1'b0;
  logic [1:0]  size1 = 2'b10;
  logic [31:0] addr1 = '0, wd1 = '0, rd1;
  logic        rdy1, err1;

  int vectors = 0;
  int miscompares = 0;

  int          lat;
  logic [31:0] got_rd;
  logic        got_err;
  int          pulses;

  always #5 clk = ~clk;

  data_mem_sized #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .sign_ext(sx0),
    .address(addr0), .write_data(wd0), .read_data(rd0), .ready(rdy0), .err(err0)
  );

  data_mem_sized #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .size(size1), .sign_ext(sx1),
    .address(addr1), .write_data(wd1), .read_data(rd1), .ready(rdy1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one access on instance d and wait (bounded) for its ready pulse.
  task automatic acc(input int d, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    if (d == 0) begin
      req0 = 1'b1; we0 = w; size0 = sz; sx0 = sx; addr0 = a; wd0 = wd;
    end else begin
      req1 = 1'b1; we1 = w; size1 = sz; sx1 = sx; addr1 = a; wd1 = wd;
    end
    lat = 0;
    got_rd = 'x;
    got_err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      if ((d == 0) ? rdy0 : rdy1) begin
        lat     = k;
        got_rd  = (d == 0) ? rd0 : rd1;
        got_err = (d == 0) ? err0 : err1;
        break;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL timeout: observed no ready expected ready within 20 cycles");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready0", {31'b0, rdy0}, 32'h0);
    check("rst_err0", {31'b0, err0}, 32'h0);
    check("rst_rd0", rd0, 32'h0);
    check("rst_ready1", {31'b0, rdy1}, 32'h0);
    check("rst_rd1", rd1, 32'h0);
    rst = 1'b0;

    acc(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_err", {31'b0, got_err}, 32'h0);
    check("sw_rd_held", got_rd, 32'h0);
    acc(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_data", got_rd, 32'hDEADBEEF);
    check("lw_err", {31'b0, got_err}, 32'h0);
    @(negedge clk);
    check("ready_one_cycle", {31'b0, rdy0}, 32'h0);

    acc(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680);
    check("sb_rd_held", got_rd, 32'hDEADBEEF);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("sb_word", got_rd, 32'hDEAD80EF);
    acc(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lb", got_rd, 32'hFFFFFF80);
    acc(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lbu", got_rd, 32'h00000080);

    acc(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD8001);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("sh_word", got_rd, 32'h800180EF);
    acc(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lh", got_rd, 32'hFFFF8001);
    acc(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lhu", got_rd, 32'h00008001);
    acc(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lh_low", got_rd, 32'hFFFF80EF);
    acc(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lbu_lane3", got_rd, 32'h00000080);
    acc(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    check("lw_ignores_sx", got_rd, 32'h800180EF);

    acc(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h11111111);
    check("sw_mis_err", {31'b0, got_err}, 32'h1);
    check("sw_mis_lat", lat, 2);
    acc(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h2222);
    check("sh_mis_err", {31'b0, got_err}, 32'h1);
    check("sh_mis_rd", got_rd, 32'h800180EF);
    acc(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("sz11_err", {31'b0, got_err}, 32'h1);
    check("sz11_rd", got_rd, 32'h800180EF);
    acc(0, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    check("lh_mis_err", {31'b0, got_err}, 32'h1);
    check("lh_mis_rd", got_rd, 32'h800180EF);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("mis_untouched", got_rd, 32'h800180EF);
    check("err_cleared", {31'b0, got_err}, 32'h0);
    @(negedge clk);
    check("err_low_idle", {31'b0, err0}, 32'h0);

    acc(0, 1'b1, 2'b10, 1'b0, 32'h4004, 32'h11223344);
    acc(0, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);
    check("wrap_alias", got_rd, 32'h11223344);

    // Wait-state instance: latched fields must survive input changes during WAIT.
    acc(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
    check("w3_sw_lat", lat, 5);
    acc(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h55555555);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; sx1 = 1'b0; addr1 = 32'h40; wd1 = '0;
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        req1 = k[0]; we1 = 1'b1; addr1 = 32'h44; wd1 = 32'h0; size1 = 2'b00;
      end else begin
        req1 = 1'b0;
      end
      if (rdy1) begin
        pulses++;
        check("w3_ready_cycle", k, 5);
        check("w3_latched_data", rd1, 32'hCAFEF00D);
      end
    end
    check("w3_pulses", pulses, 1);
    acc(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    check("w3_no_stray_write", got_rd, 32'h55555555);

    acc(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; size1 = 2'b10; addr1 = 32'h20; wd1 = 32'h12345678;
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req1 = 1'b0;
      rst  = (k == 4);
      if (rdy1) pulses++;
    end
    check("abort_no_ready", pulses, 0);
    check("abort_rd_reset", rd1, 32'h0);
    acc(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("abort_no_write", got_rd, 32'hA5A5A5A5);
    check("abort_lat_after", lat, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
